// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream master.
// The buffer depth is fixed at two entries so that the FIFO's one-cycle read latency can be absorbed.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_e;

    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read pins plus the downstream valid/ready stream, seen from the reader (master).
// The FIFO and the stream consumer side use the slave modport.
interface fifo_stream_reader_if #(
    parameter int unsigned DWIDTH = 8
) ();

    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_data;
    logic              fifo_rd;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer between the FIFO data pins and the stream output.
// Slot 0 is always the head; a pop shifts slot 1 forward.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DWIDTH-1:0] head_data,
    output logic              head_valid
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [DWIDTH-1:0] slot0_q;
    logic [DWIDTH-1:0] slot1_q;
    logic [1:0]        occ_q;
    logic              pop_ok;
    logic              push_ok;
    logic              wr_hi;

    always_comb begin
        pop_ok  = pop && (occ_q != 2'd0);
        push_ok = push && ((occ_q != FULL) || pop_ok);
        // The new word lands behind whatever remains once this cycle's pop has retired the head.
        wr_hi   = (occ_q == FULL) || ((occ_q == 2'd1) && !pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            if (pop_ok) begin
                slot0_q <= slot1_q;
            end
            if (push_ok) begin
                if (wr_hi) begin
                    slot1_q <= push_data;
                end else begin
                    slot0_q <= push_data;
                end
            end
            unique case ({push_ok, pop_ok})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ        = occ_q;
    assign head_data  = slot0_q;
    assign head_valid = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO and presents the words as a valid/ready stream framed into bursts.
// Reads are only issued when the buffer can take the word, so back-pressure never loses data.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_out
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [1:0] FULL      = 2'(BUF_DEPTH);

    rd_state_e         state_q;
    logic              inflight_q;
    logic [7:0]        beat_q;
    logic [CNT_W-1:0]  words_q;
    logic [1:0]        occ;
    logic [1:0]        held;
    logic [DWIDTH-1:0] head_data;
    logic              head_valid;
    logic              xfer;

    rd_skid_buf #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.fifo_data),
        .pop       (xfer),
        .occ       (occ),
        .head_data (head_data),
        .head_valid(head_valid)
    );

    // Words already owned by the reader: buffered plus the one the FIFO is returning now.
    assign held = occ + {1'b0, inflight_q};
    assign xfer = head_valid && bus.m_ready;

    assign bus.fifo_rd = (state_q == RUN) && !bus.fifo_empty && (held < FULL);
    assign bus.m_valid = head_valid;
    assign bus.m_data  = head_data;
    assign bus.m_last  = (beat_q == LAST_BEAT) && head_valid;
    assign busy        = (state_q != IDLE);
    assign words_out   = words_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            beat_q     <= 8'd0;
            words_q    <= '0;
        end else begin
            inflight_q <= bus.fifo_rd;
            if (xfer) begin
                beat_q  <= (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
                words_q <= words_q + CNT_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= (held != 2'd0) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        state_q <= RUN;
                    end else if (held == 2'd0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: a queue-based model of the reader is compared every cycle against two
// instances (BURST_LEN=4/CNT_W=16 and BURST_LEN=1/CNT_W=4) sharing the same FIFO and consumer.
module tb_fifo_stream_reader;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int BL_A    = 4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       enable     = 1'b0;
    logic       m_ready    = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       busy_a;
    logic       busy_b;
    logic [15:0] words_a;
    logic [3:0]  words_b;

    fifo_stream_reader_if #(.DWIDTH(8)) bus_a ();
    fifo_stream_reader_if #(.DWIDTH(8)) bus_b ();

    assign bus_a.fifo_empty = fifo_empty;
    assign bus_a.fifo_data  = fifo_data;
    assign bus_a.m_ready    = m_ready;
    assign bus_b.fifo_empty = fifo_empty;
    assign bus_b.fifo_data  = fifo_data;
    assign bus_b.m_ready    = m_ready;

    fifo_stream_reader #(.DWIDTH(8), .BURST_LEN(4), .CNT_W(16)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus_a),
        .busy     (busy_a),
        .words_out(words_a)
    );

    fifo_stream_reader #(.DWIDTH(8), .BURST_LEN(1), .CNT_W(4)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus_b),
        .busy     (busy_b),
        .words_out(words_b)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fq: the bench FIFO; mq: the model's view of the same FIFO contents.
    logic [7:0] fq[$];
    logic [7:0] mq[$];
    logic [7:0] pend[$];
    logic [7:0] mbuf[$];
    logic [7:0] log_q[$];
    bit         last_q[$];
    int         m_state = S_IDLE;
    bit         m_infl = 1'b0;
    logic [7:0] m_infl_word = 8'h00;
    int         m_beat = 0;
    int         m_words = 0;
    bit         init = 1'b0;
    logic       rd_s = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model + FIFO, advanced once per rising edge.
    initial begin : env
        int         e_held;
        bit         e_rd;
        bit         e_xfer;
        logic [7:0] w;
        forever begin
            @(posedge clk);
            e_held = mbuf.size() + int'(m_infl);
            e_rd   = (m_state == S_RUN) && (mq.size() != 0) && (e_held < 2);
            if (rst_n) begin
                if (init && e_rd) void'(mq.pop_front());
                mbuf.delete();
                m_state = S_IDLE;
                m_infl  = 1'b0;
                m_beat  = 0;
                m_words = 0;
                init    = 1'b1;
            end else if (init) begin
                e_xfer = (mbuf.size() != 0) && m_ready;
                if (e_xfer) begin
                    w = mbuf.pop_front();
                    log_q.push_back(w);
                    last_q.push_back(m_beat == BL_A - 1);
                    m_beat = (m_beat + 1) % BL_A;
                    m_words++;
                end
                if (m_infl) mbuf.push_back(m_infl_word);
                m_infl = e_rd;
                if (e_rd) m_infl_word = mq.pop_front();
                case (m_state)
                    S_IDLE:  if (enable) m_state = S_RUN;
                    S_RUN:   if (!enable) m_state = (e_held > 0) ? S_DRAIN : S_IDLE;
                    default: begin
                        if (enable) m_state = S_RUN;
                        else if (e_held == 0) m_state = S_IDLE;
                    end
                endcase
            end
            if (rd_s === 1'b1 && fq.size() != 0) fifo_data <= fq.pop_front();
            while (pend.size() != 0) begin
                w = pend.pop_front();
                fq.push_back(w);
                mq.push_back(w);
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin : cmp
        int         c_held;
        bit         c_rd;
        bit         c_valid;
        bit         prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            rd_s = bus_a.fifo_rd;
            if (init) begin
                c_held  = mbuf.size() + int'(m_infl);
                c_rd    = (m_state == S_RUN) && (mq.size() != 0) && (c_held < 2);
                c_valid = (mbuf.size() != 0);
                chk("a_fifo_rd", 32'(bus_a.fifo_rd), 32'(c_rd));
                chk("b_fifo_rd", 32'(bus_b.fifo_rd), 32'(c_rd));
                chk("a_m_valid", 32'(bus_a.m_valid), 32'(c_valid));
                chk("b_m_valid", 32'(bus_b.m_valid), 32'(c_valid));
                if (c_valid) begin
                    chk("a_m_data", 32'(bus_a.m_data), 32'(mbuf[0]));
                    chk("b_m_data", 32'(bus_b.m_data), 32'(mbuf[0]));
                end
                chk("a_m_last", 32'(bus_a.m_last), 32'(c_valid && (m_beat == BL_A - 1)));
                chk("b_m_last", 32'(bus_b.m_last), 32'(c_valid));
                chk("a_busy", 32'(busy_a), 32'(m_state != S_IDLE));
                chk("b_busy", 32'(busy_b), 32'(m_state != S_IDLE));
                chk("a_words_out", 32'(words_a), 32'(m_words % 65536));
                chk("b_words_out", 32'(words_b), 32'(m_words % 16));
                if (prev_stall) chk("hold_data", 32'(bus_a.m_data), 32'(prev_data));
                prev_stall = bus_a.m_valid && !m_ready && !rst_n;
                prev_data  = bus_a.m_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int left = budget;
        while (log_q.size() < n && left > 0) begin
            tick(1);
            left--;
        end
        checks++;
        if (log_q.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d beats want %0d (timeout)", name, log_q.size(), n);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_fifo_rd"}, 32'(bus_a.fifo_rd), 0);
        chk({tag, "_m_valid"}, 32'(bus_a.m_valid), 0);
        chk({tag, "_m_data"}, 32'(bus_a.m_data), 0);
        chk({tag, "_m_last"}, 32'(bus_a.m_last), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_words_out"}, 32'(words_a), 0);
    endtask

    initial begin : stim
        int guard;
        // Reset then idle with an empty FIFO.
        rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
        tick(2);
        chk_zero_outputs("reset");
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("idle_empty_no_rd", 32'(bus_a.fifo_rd), 0);
        end
        chk("run_busy", 32'(busy_a), 1);

        // Streaming burst 0x11..0x18, then 9 more words to wrap the 4-bit counter.
        enable = 1'b0; rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) pend.push_back(8'(8'h11 + i));
        tick(1);
        log_q.delete(); last_q.delete();
        enable = 1'b1; m_ready = 1'b1;
        wait_log(8, 60, "stream8");
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk("stream_data", 32'(log_q[i]), 32'(8'h11 + i));
            chk("stream_last", 32'(last_q[i]), 32'(i == 3 || i == 7));
        end
        chk("stream_words_a", 32'(words_a), 8);
        for (int i = 0; i < 9; i++) pend.push_back(8'(8'h19 + i));
        wait_log(17, 80, "stream17");
        chk("wrap_words_b", 32'(words_b), 1);
        chk("wrap_words_a", 32'(words_a), 17);

        // Back-pressure with m_ready 1,0,0 repeating.
        log_q.delete(); last_q.delete();
        for (int i = 0; i < 6; i++) pend.push_back(8'(8'hA0 + i));
        guard = 0;
        while (log_q.size() < 6 && guard < 80) begin
            m_ready = (guard % 3 == 0);
            tick(1);
            guard++;
        end
        m_ready = 1'b1;
        chk("bp_count", 32'(log_q.size()), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk("bp_data", 32'(log_q[i]), 32'(8'hA0 + i));

        // Disable the cycle after a read; in-flight and buffered words still drain.
        log_q.delete(); last_q.delete();
        for (int i = 0; i < 6; i++) pend.push_back(8'(8'hB0 + i));
        guard = 0;
        while (bus_a.fifo_rd !== 1'b1 && guard < 20) begin
            tick(1);
            guard++;
        end
        chk("dis_saw_rd", 32'(bus_a.fifo_rd), 1);
        tick(1);
        enable = 1'b0;
        tick(10);
        chk("dis_busy_low", 32'(busy_a), 0);
        chk("dis_fifo_left", 32'(fq.size() != 0), 1);
        enable = 1'b1;
        wait_log(6, 60, "dis_resume");
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk("dis_data", 32'(log_q[i]), 32'(8'hB0 + i));

        // Reset with a full buffer: the stream resumes at the next FIFO word, beat counter at 0.
        log_q.delete(); last_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) pend.push_back(8'(8'hC0 + i));
        tick(8);
        chk("mid_full_valid", 32'(bus_a.m_valid), 1);
        rst_n = 1'b1;
        tick(1);
        chk_zero_outputs("mid_reset");
        rst_n = 1'b0; m_ready = 1'b1;
        wait_log(4, 40, "mid_resume");
        if (log_q.size() >= 4) begin
            chk("mid_first", 32'(log_q[0]), 32'(8'hC2));
            chk("mid_last_beat", 32'(last_q[3]), 1);
        end
        chk("mid_words_a", 32'(words_a), 4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            enable  = ($urandom_range(7) != 0);
            m_ready = $urandom_range(1);
            if ($urandom_range(1) == 1) pend.push_back(8'($urandom));
            rst_n = ($urandom_range(199) == 0);
            tick(1);
        end
        rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
        tick(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
